// File: rtl/seq_1011_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_1011_frame_tx
// Description : Serial frame transmitter: sync 1011, DATA_W-bit payload MSB
//               first, optional even parity (SEQ_1011_TX_PARITY_EN), GAP idles.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_1011_frame_tx #(
    parameter int   DATA_W   = 8,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_active,
    output logic              frame_done
);

    localparam int c_M1  = (DATA_W > GAP) ? DATA_W : GAP;
    localparam int c_MAX = (c_M1 > 4) ? c_M1 : 4;
    localparam int c_CW  = $clog2(c_MAX) + 1;

    localparam logic [c_CW-1:0] c_SYNC_LAST = c_CW'(3);
    localparam logic [c_CW-1:0] c_DATA_LAST = c_CW'(DATA_W - 1);
    localparam logic [c_CW-1:0] c_DATA_PEN  = c_CW'((DATA_W > 1) ? DATA_W - 2 : 0);
    localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [3:0]      c_SYNC      = 4'b1011;

`ifdef SEQ_1011_TX_PARITY_EN
    localparam logic c_PAR = 1'b1;
`else
    localparam logic c_PAR = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
`ifdef SEQ_1011_TX_PARITY_EN
        S_PAR  = 3'd3,
`endif
        S_GAP  = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic              r_out, w_out_nxt;
    logic              r_active, w_active_nxt;
    logic              r_done, w_done_nxt;
    logic              w_hs;
`ifdef SEQ_1011_TX_PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    assign tx_ready   = (r_state == S_IDLE) && !rst;
    assign tx_out     = r_out;
    assign tx_active  = r_active;
    assign frame_done = r_done;
    assign w_hs       = tx_valid && tx_ready;

    // Outputs are computed one cycle ahead so the line bits leave a flop.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shreg_nxt  = r_shreg;
        w_out_nxt    = IDLE_LVL;
        w_active_nxt = 1'b0;
        w_done_nxt   = 1'b0;
`ifdef SEQ_1011_TX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt  = S_SYNC;
                    w_cnt_nxt    = '0;
                    w_shreg_nxt  = tx_data;
                    w_out_nxt    = c_SYNC[3];
                    w_active_nxt = 1'b1;
`ifdef SEQ_1011_TX_PARITY_EN
                    w_par_nxt    = ^tx_data;
`endif
                end
            end
            S_SYNC: begin
                w_active_nxt = 1'b1;
                if (r_cnt == c_SYNC_LAST) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = r_shreg[DATA_W-1];
                    w_shreg_nxt = r_shreg << 1;
                    w_done_nxt  = (c_DATA_LAST == '0) && !c_PAR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_out_nxt = c_SYNC[2'd2 - r_cnt[1:0]];
                end
            end
            S_DATA: begin
                if (r_cnt == c_DATA_LAST) begin
                    w_cnt_nxt = '0;
`ifdef SEQ_1011_TX_PARITY_EN
                    w_state_nxt  = S_PAR;
                    w_out_nxt    = r_par;
                    w_active_nxt = 1'b1;
                    w_done_nxt   = 1'b1;
`else
                    w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
`endif
                end else begin
                    w_cnt_nxt    = r_cnt + 1'b1;
                    w_out_nxt    = r_shreg[DATA_W-1];
                    w_shreg_nxt  = r_shreg << 1;
                    w_active_nxt = 1'b1;
                    w_done_nxt   = (r_cnt == c_DATA_PEN) && !c_PAR;
                end
            end
`ifdef SEQ_1011_TX_PARITY_EN
            S_PAR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            end
`endif
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_shreg_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shreg  <= '0;
            r_out    <= IDLE_LVL;
            r_active <= 1'b0;
            r_done   <= 1'b0;
`ifdef SEQ_1011_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_out    <= w_out_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
`ifdef SEQ_1011_TX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_1011_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_1011_frame_tx
// Description : Self-checking bench for seq_1011_frame_tx (vector table, corner
//               sequences, randomized traffic against a frame-level model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_1011_frame_tx;

    localparam int DW = 8;
    localparam int GP = 1;
`ifdef SEQ_1011_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = 4 + DW + PB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    wire        tx_ready, tx_out, tx_active, frame_done;
    wire        tx_ready2, tx_out2, tx_active2, frame_done2;

    int total = 0;
    int bad   = 0;

    seq_1011_frame_tx #(.DATA_W(DW), .GAP(GP), .IDLE_LVL(1'b0)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .tx_active(tx_active),
        .frame_done(frame_done)
    );

    seq_1011_frame_tx #(.DATA_W(DW), .GAP(0), .IDLE_LVL(1'b0)) dut_g0 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_out(tx_out2), .tx_active(tx_active2),
        .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    // Frames written out as sync(4) + payload(8) + parity(1); bit 12 is first.
    typedef struct {
        logic [7:0]  d;
        logic [12:0] f;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic fbit(input logic [12:0] f, input int i);
        return f[12-i];
    endfunction

    task automatic wait_ready(input string nm);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready_wait"}, tx_ready, 1);
    endtask

    task automatic check_frame(input string nm, input logic [12:0] f,
                               input logic [7:0] nd, input logic nv);
        for (int i = 0; i < L; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_out%0d", nm, i), tx_out, fbit(f, i));
            chk($sformatf("%s_act%0d", nm, i), tx_active, 1);
            chk($sformatf("%s_done%0d", nm, i), frame_done, (i == L - 1));
            if (i == 0) begin
                tx_data  = nd;
                tx_valid = nv;
            end
        end
    endtask

    task automatic check_tail(input string nm);
        for (int g = 0; g <= GP; g++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_idle_out%0d", nm, g), tx_out, 0);
            chk($sformatf("%s_idle_act%0d", nm, g), tx_active, 0);
            chk($sformatf("%s_idle_done%0d", nm, g), frame_done, 0);
            chk($sformatf("%s_ready%0d", nm, g), tx_ready, (g == GP));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  q[$];
        logic [2:0]  e;
        logic [3:0]  sy;
        logic [31:0] s_out, s_act, s_done, x_out, x_act, x_done;
        logic [12:0] f_ff, f_00;
        logic        b;
        int          busy;
        int          ndone;

        tbl[0] = '{8'hA5, 13'b1011_10100101_0};
        tbl[1] = '{8'h3C, 13'b1011_00111100_0};
        tbl[2] = '{8'h81, 13'b1011_10000001_0};
        tbl[3] = '{8'h01, 13'b1011_00000001_1};
        tbl[4] = '{8'hFF, 13'b1011_11111111_0};
        tbl[5] = '{8'h00, 13'b1011_00000000_0};
        tbl[6] = '{8'h07, 13'b1011_00000111_1};
        tbl[7] = '{8'h03, 13'b1011_00000011_0};

        // Reset held with a producer already waiting
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
        tx_valid2 = 1'b0; tx_data2 = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_out", tx_out, 0);
            chk("rst_act", tx_active, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_ready", tx_ready, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_ready", tx_ready, 1);
        check_frame("rel_a5", tbl[0].f, 8'h00, 1'b0);
        check_tail("rel_a5");

        foreach (tbl[k]) begin
            wait_ready($sformatf("tbl%0d", k));
            tx_data  = tbl[k].d;
            tx_valid = 1'b1;
            check_frame($sformatf("tbl%0d", k), tbl[k].f, 8'($urandom), 1'b0);
            check_tail($sformatf("tbl%0d", k));
        end

        // Backpressure: new word offered while a frame is in flight
        wait_ready("bp");
        tx_data = 8'hA5; tx_valid = 1'b1;
        check_frame("bp_a5", tbl[0].f, 8'h3C, 1'b1);
        check_tail("bp_gap");
        check_frame("bp_3c", tbl[1].f, 8'h00, 1'b0);
        check_tail("bp_3c");

        // Back-to-back on the GAP=0 instance
        f_ff = 13'b1011_11111111_0;
        f_00 = 13'b1011_00000000_0;
        s_out = '0; s_act = '0; s_done = '0;
        x_out = '0; x_act = '0; x_done = '0;
        ndone = 0;
        for (int i = 0; i < L; i++) begin
            x_out  = {x_out[30:0], fbit(f_ff, i)};
            x_act  = {x_act[30:0], 1'b1};
            x_done = {x_done[30:0], (i == L - 1)};
        end
        x_out = {x_out[30:0], 1'b0}; x_act = {x_act[30:0], 1'b0}; x_done = {x_done[30:0], 1'b0};
        for (int i = 0; i < L; i++) begin
            x_out  = {x_out[30:0], fbit(f_00, i)};
            x_act  = {x_act[30:0], 1'b1};
            x_done = {x_done[30:0], (i == L - 1)};
        end
        x_out = {x_out[30:0], 1'b0}; x_act = {x_act[30:0], 1'b0}; x_done = {x_done[30:0], 1'b0};
        @(negedge clk);
        tx_data2 = 8'hFF; tx_valid2 = 1'b1;
        for (int ed = 0; ed < 2 * L + 2; ed++) begin
            @(posedge clk); #1;
            s_out  = {s_out[30:0], tx_out2};
            s_act  = {s_act[30:0], tx_active2};
            s_done = {s_done[30:0], frame_done2};
            if (frame_done2) ndone++;
            if (ed == 0) tx_data2 = 8'h00;
            if (ed == L + 1) tx_valid2 = 1'b0;
        end
        chk("b2b_out_stream", s_out, x_out);
        chk("b2b_act_stream", s_act, x_act);
        chk("b2b_done_stream", s_done, x_done);
        chk("b2b_done_count", ndone, 2);

        // Asynchronous reset in the middle of a frame
        wait_ready("mid");
        tx_data = 8'hA5; tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_out%0d", i), tx_out, fbit(tbl[0].f, i));
            if (i == 0) tx_valid = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out", tx_out, 0);
        chk("mid_rst_act", tx_active, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_ready", tx_ready, 0);
        @(posedge clk); #1;
        chk("mid_hold_done", frame_done, 0);
        chk("mid_hold_out", tx_out, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rel_ready", tx_ready, 1);
        tx_data = 8'h5A; tx_valid = 1'b1;
        check_frame("mid_5a", 13'b1011_01011010_0, 8'h00, 1'b0);
        check_tail("mid_5a");

        // Randomized traffic against a frame-level model
        busy = 0;
        sy   = 4'b1011;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 2) != 0);
            tx_data  = 8'($urandom);
            chk("rnd_ready", tx_ready, (busy == 0));
            @(posedge clk);
            if (tx_valid && busy == 0) begin
                for (int i = 0; i < L; i++) begin
                    if (i < 4)           b = sy[3-i];
                    else if (i < 4 + DW) b = tx_data[DW-1-(i-4)];
                    else                 b = ^tx_data;
                    q.push_back({b, 1'b1, (i == L - 1)});
                end
                busy = L + GP;
            end else if (busy > 0) begin
                busy--;
            end
            #1;
            e = (q.size() > 0) ? q.pop_front() : 3'b000;
            chk("rnd_out", tx_out, e[2]);
            chk("rnd_act", tx_active, e[1]);
            chk("rnd_done", frame_done, e[0]);
        end
        tx_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
